circ_deint_delay: RTL

//   Parametrised per-word frame delay line for the CIRC path; successor to the

---
 rtl/circ_pkg.sv | 42 ++++
 rtl/circ_frame_ram.sv | 37 +++
 rtl/circ_deint_delay.sv | 119 +++++++++++
 3 files changed

// File: rtl/circ_pkg.sv
`default_nettype none
// ============================================================================
// circ_pkg : shared symbol types and delay-profile helpers for the CIRC path
// Rev 1.0
// ============================================================================
package circ_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int WORDS_DEF = 28;

   typedef logic [WIDTH_DEF-1:0] sym_t;

   typedef enum logic [1:0] {
      ODD_ONE     = 2'd0,
      STAGGER     = 2'd1,
      STAGGER_REV = 2'd2
   } dly_mode_e;

   // Per-word delay in frames; any unknown mode falls back to the deinterleaver stagger.
   function automatic int circ_dly(input int mode, input int i, input int words, input int unit);
      int d;
      if (mode == int'(ODD_ONE))
         d = (i % 2 == 1) ? unit : 0;
      else if (mode == int'(STAGGER_REV))
         d = i * unit;
      else
         d = (words - 1 - i) * unit;
      return d;
   endfunction

   function automatic int circ_maxdly(input int mode, input int words, input int unit);
      int m;
      m = 0;
      for (int i = 0; i < words; i++) begin
         if (circ_dly(mode, i, words, unit) > m)
            m = circ_dly(mode, i, words, unit);
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/circ_frame_ram.sv
`default_nettype none
// ============================================================================
// circ_frame_ram : circular frame store, one write port, one read address per word
// Rev 1.0
// ============================================================================
module circ_frame_ram #(
   parameter int DEPTH = 1,
   parameter int WORDS = 2,
   parameter int BITS  = 9,
   parameter int AW    = 1
) (
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [AW-1:0]              waddr_i,
   input  logic [WORDS-1:0][BITS-1:0] wdata_i,
   input  logic [WORDS-1:0][AW-1:0]   raddr_i,
   output logic [WORDS-1:0][BITS-1:0] rdata_o
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WORDS-1:0][BITS-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i)
         mem_q[waddr_i[IW-1:0]] <= wdata_i;
   end

   // Asynchronous read sees the pre-edge contents, giving read-before-write at the slot being written.
   always_comb begin
      rdata_o = '0;
      for (int w = 0; w < WORDS; w++)
         rdata_o[w] = mem_q[raddr_i[w][IW-1:0]][w];
   end

endmodule
`default_nettype wire

// File: rtl/circ_deint_delay.sv
`default_nettype none
// ============================================================================
// circ_deint_delay : per-word whole-frame delay line with erasure tracking
// Rev 1.0
// ============================================================================
module circ_deint_delay
   import circ_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int WORDS = WORDS_DEF,
   parameter int UNIT  = 4,
   parameter int MODE  = 1
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic [WORDS-1:0][WIDTH-1:0] D,
   input  logic [WORDS-1:0]            D_ERA,
   input  logic                        D_VALID,
   input  logic                        FLUSH,
   output logic [WORDS-1:0][WIDTH-1:0] Q,
   output logic [WORDS-1:0]            Q_ERA,
   output logic                        Q_VALID,
   output logic                        FILLED
);

   localparam int MAXDLY = circ_maxdly(MODE, WORDS, UNIT);
   localparam int CW     = $clog2(MAXDLY + 1);
   localparam int EW     = WIDTH + 1;

   logic [CW-1:0]               wptr_q, wptr_d;
   logic [CW-1:0]               fill_q, fill_d;
   logic [WORDS-1:0][WIDTH-1:0] q_q, q_d;
   logic [WORDS-1:0]            q_era_q, q_era_d;
   logic                        q_valid_q, q_valid_d;
   logic                        filled_q, filled_d;

   logic [CW-1:0]               w_fill_eff;
   logic [WORDS-1:0][CW-1:0]    w_dly;
   logic [WORDS-1:0][CW-1:0]    w_raddr;
   logic [WORDS-1:0][EW-1:0]    w_wdata;
   logic [WORDS-1:0][EW-1:0]    w_rdata;
   logic [WORDS-1:0][EW-1:0]    w_sel;

   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
         localparam int DLY = circ_dly(MODE, gi, WORDS, UNIT);
         logic [CW:0] w_sum;

         assign w_dly[gi]   = CW'(DLY);
         assign w_wdata[gi] = {D_ERA[gi], D[gi]};
         // (wptr - DLY) mod MAXDLY, formed as wptr + (MAXDLY - DLY) so it stays exact for any depth.
         assign w_sum       = {1'b0, wptr_q} + (CW+1)'(MAXDLY - DLY);
         assign w_raddr[gi] = (w_sum >= (CW+1)'(MAXDLY)) ? CW'(w_sum - (CW+1)'(MAXDLY))
                                                          : CW'(w_sum);
         assign w_sel[gi]   = (DLY == 0) ? w_wdata[gi] : w_rdata[gi];
      end
   endgenerate

   circ_frame_ram #(
      .DEPTH (MAXDLY),
      .WORDS (WORDS),
      .BITS  (EW),
      .AW    (CW)
   ) u_ram (
      .clk_i   (CLK),
      .we_i    (D_VALID & RST_N),
      .waddr_i (wptr_q),
      .wdata_i (w_wdata),
      .raddr_i (w_raddr),
      .rdata_o (w_rdata)
   );

   always_comb begin
      w_fill_eff = FLUSH ? '0 : fill_q;
      wptr_d     = wptr_q;
      fill_d     = fill_q;
      q_d        = q_q;
      q_era_d    = q_era_q;
      q_valid_d  = 1'b0;
      if (D_VALID) begin
         for (int i = 0; i < WORDS; i++) begin
            q_d[i]     = w_sel[i][WIDTH-1:0];
            // A word whose delay reaches back past the start of fill has no real history yet.
            q_era_d[i] = w_sel[i][WIDTH] | (w_fill_eff < w_dly[i]);
         end
         wptr_d    = (wptr_q == CW'(MAXDLY - 1)) ? '0 : wptr_q + CW'(1);
         fill_d    = (w_fill_eff == CW'(MAXDLY)) ? w_fill_eff : w_fill_eff + CW'(1);
         q_valid_d = 1'b1;
      end else if (FLUSH) begin
         fill_d = '0;
      end
      filled_d = (fill_d == CW'(MAXDLY));
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wptr_q    <= '0;
         fill_q    <= '0;
         q_q       <= '0;
         q_era_q   <= '1;
         q_valid_q <= 1'b0;
         filled_q  <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         fill_q    <= fill_d;
         q_q       <= q_d;
         q_era_q   <= q_era_d;
         q_valid_q <= q_valid_d;
         filled_q  <= filled_d;
      end
   end

   assign Q       = q_q;
   assign Q_ERA   = q_era_q;
   assign Q_VALID = q_valid_q;
   assign FILLED  = filled_q;

endmodule
`default_nettype wire
